// File: rtl/dec_scan.sv
// Multiplexed 4-digit BCD to 7-segment scanner with per-frame input capture.
// Define DEC_SCAN_LZB_EN to blank leading zeros on digits 1..3.
module dec_scan #(
  parameter int unsigned F_CLK  = 50_000_000,
  parameter int unsigned F_SCAN = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_dec,
  output logic [6:0]  o_seg,
  output logic [3:0]  o_an,
  output logic        o_frame
);

  localparam int unsigned DIV = F_CLK / F_SCAN;
  localparam int unsigned CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("dec_scan: F_CLK/F_SCAN must be at least 2");
    end
  endgenerate

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;

  logic          tick;
  logic          capture;
  logic [1:0]    nxt_idx;
  logic [15:0]   src;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    nxt_seg;

  // Digit 0 is decoded straight from i_dec on the capture edge so the new
  // frame appears on the same edge the shadow register loads.
  always_comb begin
    tick    = (cnt == LAST);
    capture = tick && (idx == 2'd3);
    nxt_idx = idx + 2'd1;
    src     = capture ? i_dec : shadow;
    nib     = src[{nxt_idx, 2'b00} +: 4];
    blank   = 1'b0;
`ifdef DEC_SCAN_LZB_EN
    case (nxt_idx)
      2'd1:    blank = (src[15:4]  == '0);
      2'd2:    blank = (src[15:8]  == '0);
      2'd3:    blank = (src[15:12] == '0);
      default: blank = 1'b0;
    endcase
`endif
    nxt_seg = blank ? 7'h7F : seg_decode(nib);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= 2'd3;
      shadow  <= '0;
      o_an    <= '1;
      o_seg   <= '1;
      o_frame <= 1'b0;
    end else begin
      o_frame <= capture;
      cnt     <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx   <= nxt_idx;
        o_an  <= ~(4'b0001 << nxt_idx);
        o_seg <= nxt_seg;
      end
      if (capture)
        shadow <= i_dec;
    end
  end

endmodule

// File: tb/tb_dec_scan.sv
// Scoreboard bench for dec_scan: a cycle-count model predicts each edge's
// outputs, a monitor compares them one cycle at a time.
module tb_dec_scan;

  localparam int unsigned F_CLK  = 8;
  localparam int unsigned F_SCAN = 2;
  localparam int unsigned DIV    = F_CLK / F_SCAN;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] i_dec;
  logic [6:0]  o_seg;
  logic [3:0]  o_an;
  logic        o_frame;

  dec_scan #(.F_CLK(F_CLK), .F_SCAN(F_SCAN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_dec   (i_dec),
    .o_seg   (o_seg),
    .o_an    (o_an),
    .o_frame (o_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        q[$];
  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned cyc    = 0;

  // Model state: edges since reset release, shown digit, captured frame.
  int unsigned n        = 0;
  int          m_digit  = -1;
  logic [15:0] m_shadow = '0;
  exp_t        m_out    = '{an: 4'hF, seg: 7'h7F, frame: 1'b0};

  function automatic logic [6:0] ref_seg(input logic [15:0] sh, input int d);
    logic [15:0] upper;
    logic [3:0]  nibble;
    upper  = sh >> (4 * d);
    nibble = upper[3:0];
`ifdef DEC_SCAN_LZB_EN
    if (d > 0 && upper == 16'h0000) return 7'h7F;
`endif
    return SEG_TAB[nibble];
  endfunction

  task automatic step(input logic r, input logic [15:0] v);
    int d;
    @(negedge clk);
    rst_n = r;
    i_dec = v;
    if (!r) begin
      n        = 0;
      m_digit  = -1;
      m_shadow = '0;
      m_out    = '{an: 4'hF, seg: 7'h7F, frame: 1'b0};
    end else begin
      n++;
      m_out.frame = 1'b0;
      if (n % DIV == 0) begin
        d = int'(((n / DIV) - 1) % 4);
        if (d == 0) m_shadow = v;
        m_digit     = d;
        m_out.an    = ~(4'b0001 << d);
        m_out.seg   = ref_seg(m_shadow, d);
        m_out.frame = (d == 0);
      end
    end
    q.push_back(m_out);
  endtask

  function automatic logic [15:0] rand_dec();
    logic [15:0] v;
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(0, 3))
        0:       v[4*k +: 4] = 4'd0;
        1:       v[4*k +: 4] = 4'($urandom_range(10, 15));
        default: v[4*k +: 4] = 4'($urandom_range(0, 9));
      endcase
    end
    return v;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (o_an === e.an && o_seg === e.seg && o_frame === e.frame)
          passes++;
        else
          $display("FAIL scan cyc=%0d an=%b exp %b seg=%h exp %h frame=%b exp %b",
                   cyc, o_an, e.an, o_seg, e.seg, o_frame, e.frame);
      end
    end
  end

  // Driver
  initial begin
    logic [15:0] v;
    rst_n = 1'b0;
    i_dec = '0;

    step(1'b0, 16'h0000);
    step(1'b0, 16'h0000);
    repeat (4 * DIV * 3) step(1'b1, 16'h1234);

    for (int k = 0; k < 64 && m_digit != 1; k++) step(1'b1, 16'h1234);
    repeat (4 * DIV * 2) step(1'b1, 16'h9999);
    repeat (4 * DIV * 2) step(1'b1, 16'h00A7);
    repeat (4 * DIV * 2) step(1'b1, 16'h0000);
    repeat (4 * DIV * 2) step(1'b1, 16'h0900);

    for (int k = 0; k < 64 && m_digit != 2; k++) step(1'b1, 16'h5678);
    step(1'b0, 16'h5678);
    repeat (4 * DIV * 2) step(1'b1, 16'h5678);

    v = rand_dec();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) v = rand_dec();
      step(($urandom_range(0, 199) != 0), v);
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain pending=%0d exp 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
